// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one data-memory port between the CPU MEM stage and the AES
//   key/data loader, and produces the pipeline stall for the CPU side.
// Ports
//   clk, rst            : clock, async active-low reset
//   cpu_rd/wr/addr/wdata: CPU MEM-stage request (store wins over load)
//   cpu_rdata, cpu_stall: CPU load data, pipeline freeze
//   aes_req/we/addr/wdata: AES request (level, held until aes_done)
//   aes_gnt, aes_done, aes_rdata: AES port ownership, completion, read data
//   mem_req/we/addr/wdata, mem_rdata, mem_ack: memory req/ack handshake
module dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        aes_req,
  input  logic        aes_we,
  input  logic [31:0] aes_addr,
  input  logic [31:0] aes_wdata,
  output logic        aes_gnt,
  output logic        aes_done,
  output logic [31:0] aes_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, CPU_BUSY, AES_BUSY} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t      state, state_nx;
  logic [3:0]  starve_cnt;
  logic [31:0] rdata_q;
  logic        cpu_req, gnt_cpu, gnt_aes, ack, cpu_ack;
  mreq_t       cmd;

  assign cpu_req = cpu_rd | cpu_wr;
  // an ack with no outstanding request is meaningless and must not move the FSM
  assign ack     = mem_req & mem_ack;
  assign cpu_ack = (state == CPU_BUSY) & ack;
  assign cmd     = gnt_cpu ? mreq_t'{cpu_wr, cpu_addr, cpu_wdata}
                           : mreq_t'{aes_we, aes_addr, aes_wdata};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    gnt_cpu  = 1'b0;
    gnt_aes  = 1'b0;
    case (state)
      IDLE: begin
        // CPU has priority until it has been granted STARVE_MAX times in a row
        // over a waiting AES request
        if (cpu_req && (!aes_req || starve_cnt < SMAX)) begin
          gnt_cpu  = 1'b1;
          state_nx = CPU_BUSY;
        end else if (aes_req) begin
          gnt_aes  = 1'b1;
          state_nx = AES_BUSY;
        end
      end
      CPU_BUSY, AES_BUSY: if (ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     starve_cnt <= '0;
    else if (!aes_req || gnt_aes) starve_cnt <= '0;
    else if (gnt_cpu && starve_cnt < SMAX) starve_cnt <= starve_cnt + 4'd1;
  end

  // memory command is registered at the grant edge and frozen until ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (gnt_cpu || gnt_aes) begin
      mem_req   <= 1'b1;
      mem_we    <= cmd.we;
      mem_addr  <= cmd.addr;
      mem_wdata <= cmd.wdata;
    end else if (ack) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         rdata_q <= '0;
    else if (cpu_ack) rdata_q <= mem_rdata;
  end

  // load data bypasses the hold register in the ack cycle so the pipeline
  // can advance on that same edge
  assign cpu_rdata = cpu_ack ? mem_rdata : rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign aes_gnt   = (state == AES_BUSY);
  assign aes_done  = aes_gnt & ack;
  assign aes_rdata = mem_rdata;

endmodule
